// File: rtl/serial_adder_seq_if.sv
// Valid/ready operand and result bundle for the bit-serial adder.
// master = producer/consumer side, slave = adder side.
interface serial_adder_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell, operands shifted LSB-first, one bit per clock.
// Accepts an operand pair in IDLE, runs WIDTH cycles, holds the result in DONE until taken.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_adder_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             s_bit;
    logic             maj;
    logic [WIDTH-1:0] sum_next;

    assign s_bit    = sha_q[0] ^ shb_q[0] ^ carry_q;
    assign maj      = (sha_q[0] & shb_q[0]) | (sha_q[0] & carry_q) | (shb_q[0] & carry_q);
    assign sum_next = {s_bit, sum_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        sha_d       = sha_q;
        shb_d       = shb_q;
        sum_sr_d    = sum_sr_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sha_d      = bus.a;
                    shb_d      = bus.b;
                    carry_d    = bus.cin;
                    cnt_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                end
            end
            RUN: begin
                carry_d  = maj;
                sum_sr_d = sum_next;
                sha_d    = sha_q >> 1;
                shb_d    = shb_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // The result register takes the shifted value including this edge's final bit.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d       = sum_next;
                    cout_d      = maj;
                    cnt_d       = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sha_q       <= '0;
            shb_q       <= '0;
            sum_sr_q    <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sha_q       <= sha_d;
            shb_q       <= shb_d;
            sum_sr_q    <= sum_sr_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq at WIDTH=8 and WIDTH=2; expected results come from plain a+b+cin.
module tb_serial_adder_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_seq_if #(.WIDTH(8)) b8();
    serial_adder_seq_if #(.WIDTH(2)) b2();

    serial_adder_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    serial_adder_seq #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    typedef struct { logic [7:0] sum; logic cout; int acc; } exp8_t;
    typedef struct { logic [1:0] sum; logic cout; int acc; } exp2_t;
    exp8_t q8[$];
    exp2_t q2[$];

    bit rnd_rdy = 1'b0;
    bit fix_rdy = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out at t=%0t", name, $time);
    endtask

    // Consumer ready, changed just after the edge so the monitor sees the value used at the next edge.
    initial begin
        b8.out_ready = 1'b1;
        b2.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            b8.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : fix_rdy;
            b2.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : fix_rdy;
        end
    end

    bit seen8 = 1'b0, pidle8 = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            seen8 = 1'b0; pidle8 = 1'b0;
        end else begin
            if (pidle8) begin
                chk("w8_in_ready_after_done", b8.in_ready, 1);
                chk("w8_out_valid_after_done", b8.out_valid, 0);
                pidle8 = 1'b0;
            end
            if (b8.out_valid) begin
                if (q8.size() == 0) timeout("w8_unexpected_out_valid");
                else begin
                    if (!seen8) begin
                        chk("w8_latency", cyc - q8[0].acc, 8);
                        seen8 = 1'b1;
                    end
                    chk("w8_sum", b8.sum, q8[0].sum);
                    chk("w8_cout", b8.cout, q8[0].cout);
                    chk("w8_in_ready_in_done", b8.in_ready, 0);
                    if (b8.out_ready) begin
                        void'(q8.pop_front());
                        seen8 = 1'b0; pidle8 = 1'b1;
                    end
                end
            end
        end
    end

    bit seen2 = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst) seen2 = 1'b0;
        else if (b2.out_valid) begin
            if (q2.size() == 0) timeout("w2_unexpected_out_valid");
            else begin
                if (!seen2) begin
                    chk("w2_latency", cyc - q2[0].acc, 2);
                    seen2 = 1'b1;
                end
                chk("w2_sum", b2.sum, q2[0].sum);
                chk("w2_cout", b2.cout, q2[0].cout);
                chk("w2_in_ready_in_done", b2.in_ready, 0);
                if (b2.out_ready) begin
                    void'(q2.pop_front());
                    seen2 = 1'b0;
                end
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [8:0] r;
        int t = 0;
        @(negedge clk);
        while (!b8.in_ready && t < 200) begin @(negedge clk); t++; end
        if (!b8.in_ready) begin timeout("w8_send"); return; end
        r = {1'b0, a} + {1'b0, b} + 9'(ci);
        b8.a = a; b8.b = b; b8.cin = ci; b8.in_valid = 1'b1;
        q8.push_back('{sum: r[7:0], cout: r[8], acc: cyc + 1});
        @(negedge clk);
        b8.in_valid = 1'b0;
        b8.a = 8'($urandom); b8.b = 8'($urandom); b8.cin = 1'($urandom);
    endtask

    task automatic send2(input logic [1:0] a, input logic [1:0] b, input logic ci);
        logic [2:0] r;
        int t = 0;
        @(negedge clk);
        while (!b2.in_ready && t < 200) begin @(negedge clk); t++; end
        if (!b2.in_ready) begin timeout("w2_send"); return; end
        r = {1'b0, a} + {1'b0, b} + 3'(ci);
        b2.a = a; b2.b = b; b2.cin = ci; b2.in_valid = 1'b1;
        q2.push_back('{sum: r[1:0], cout: r[2], acc: cyc + 1});
        @(negedge clk);
        b2.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((q8.size() != 0 || q2.size() != 0 || !b8.in_ready || !b2.in_ready) && t < 500) begin
            @(negedge clk); t++;
        end
        if (t >= 500) timeout(name);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
        b2.in_valid = 1'b0; b2.a = '0; b2.b = '0; b2.cin = 1'b0;
        #1;
        chk("rst_in_ready", b8.in_ready, 1);
        chk("rst_out_valid", b8.out_valid, 0);
        chk("rst_sum", b8.sum, 0);
        chk("rst_cout", b8.cout, 0);
        chk("rst_w2_in_ready", b2.in_ready, 1);
        #22 rst = 1'b0;

        send8(8'h5A, 8'h33, 1'b0);
        send8(8'hFF, 8'h01, 1'b0);
        send8(8'hFF, 8'hFF, 1'b1);
        send8(8'h00, 8'h00, 1'b1);
        drain("drain_directed");

        // Backpressure: result must hold while the producer keeps offering other operands.
        fix_rdy = 1'b0;
        send8(8'h12, 8'h34, 1'b0);
        begin
            int t = 0;
            while (!b8.out_valid && t < 50) begin @(negedge clk); t++; end
            if (!b8.out_valid) timeout("bp_wait_valid");
        end
        repeat (5) begin
            @(negedge clk);
            b8.in_valid = 1'b1; b8.a = 8'($urandom); b8.b = 8'($urandom);
        end
        fix_rdy = 1'b1;
        @(negedge clk);
        b8.in_valid = 1'b0;
        drain("drain_backpressure");

        send8(8'h0F, 8'h01, 1'b0);
        repeat (4) begin
            @(negedge clk);
            b8.in_valid = 1'b1; b8.a = 8'hAA; b8.b = 8'h55;
        end
        b8.in_valid = 1'b0;
        drain("drain_operand_change");

        // Abort mid-run: outputs must drop at once, without waiting for a clock edge.
        send8(8'hAA, 8'h0F, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", b8.out_valid, 0);
        chk("abort_in_ready", b8.in_ready, 1);
        chk("abort_sum", b8.sum, 0);
        chk("abort_cout", b8.cout, 0);
        q8.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        send8(8'h80, 8'h80, 1'b0);
        drain("drain_after_abort");

        rnd_rdy = 1'b1;
        repeat (25) send8(8'($urandom), 8'($urandom), 1'($urandom));
        drain("drain_random8");
        rnd_rdy = 1'b0;

        send2(2'b11, 2'b01, 1'b1);
        drain("drain_w2_directed");
        rnd_rdy = 1'b1;
        repeat (12) send2(2'($urandom), 2'($urandom), 1'($urandom));
        drain("drain_random2");
        rnd_rdy = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
